// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// field/word widths, the default implemented-field limit and the parity helper.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int FIELD_W           = 3;
  localparam int WORD_W            = 12;
  localparam int PADDR_W           = FIELD_W + WORD_W;
  localparam int CNT_W             = 4;
  localparam int MAX_FIELD_DEFAULT = 1;

  // Odd parity: XOR of the data bits together with the returned bit is 1.
  function automatic logic odd_par(input logic [WORD_W-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port core storage: synchronous write, registered read, no reset on contents.
module mem_array #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one valid/ready request, programmable wait states, one-cycle response.
// Define MEM_PARITY_EN to store a parity bit per word and flag parity errors on reads.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MAX_FIELD   = MAX_FIELD_DEFAULT,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [0:FIELD_W-1] req_field,
  input  logic [0:WORD_W-1]  req_addr,
  input  logic [0:WORD_W-1]  req_wdata,
  input  logic               par_inject,
  output logic               rsp_valid,
  output logic [0:WORD_W-1]  rsp_rdata,
  output logic               rsp_nxm,
  output logic               rsp_par_err
);

  localparam int DEPTH = (MAX_FIELD + 1) * 4096;
  localparam int AW    = $clog2(DEPTH);
`ifdef MEM_PARITY_EN
  localparam int MEM_W = WORD_W + 1;
`else
  localparam int MEM_W = WORD_W;
`endif
  localparam logic [CNT_W-1:0]   WAIT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [FIELD_W-1:0] MAX_F     = FIELD_W'(MAX_FIELD);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [0:FIELD_W-1]  field_q, field_d;
  logic [0:WORD_W-1]   addr_q, addr_d;
  logic [0:WORD_W-1]   wdata_q, wdata_d;
  logic                inj_q, inj_d;

  logic                field_ok;
  logic                rd_ok;
  logic [PADDR_W-1:0]  phys_idx;
  logic [AW-1:0]       mem_addr;
  logic                mem_en;
  logic [MEM_W-1:0]    mem_wdata;
  logic [MEM_W-1:0]    mem_rdata;

  assign field_ok = (field_q <= MAX_F);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    field_d   = field_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    inj_d     = inj_q;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          field_d = req_field;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          inj_d   = par_inject;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      field_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      inj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      field_q <= field_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      inj_q   <= inj_d;
    end
  end

  // Nonexistent fields never touch the array; reset on the access edge wins over the write.
  assign phys_idx = {field_q, addr_q};
  assign mem_addr = AW'(phys_idx);
  assign mem_en   = (state_q == ST_ACCESS) && field_ok && !reset;

`ifdef MEM_PARITY_EN
  assign mem_wdata = {odd_par(wdata_q) ^ inj_q, wdata_q};
`else
  logic unused_inj;
  assign unused_inj = inj_q;
  assign mem_wdata  = wdata_q;
`endif

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (MEM_W)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (we_q),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign rd_ok     = (state_q == ST_RESP) && !we_q && field_ok;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_nxm   = (state_q == ST_RESP) && !field_ok;
  assign rsp_rdata = rd_ok ? mem_rdata[WORD_W-1:0] : '0;

`ifdef MEM_PARITY_EN
  assign rsp_par_err = rd_ok && !(^mem_rdata);
`else
  assign rsp_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (0 and 3 wait states, MAX_FIELD=1).
module tb_mem_responder;

`ifdef MEM_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset       [2];
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_we      [2];
  logic [0:2]  req_field   [2];
  logic [0:11] req_addr    [2];
  logic [0:11] req_wdata   [2];
  logic        par_inject  [2];
  logic        rsp_valid   [2];
  logic [0:11] rsp_rdata   [2];
  logic        rsp_nxm     [2];
  logic        rsp_par_err [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.MAX_FIELD(1), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_field(req_field[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .par_inject(par_inject[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_nxm(rsp_nxm[0]), .rsp_par_err(rsp_par_err[0])
  );

  mem_responder #(.MAX_FIELD(1), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_field(req_field[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .par_inject(par_inject[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_nxm(rsp_nxm[1]), .rsp_par_err(rsp_par_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0o expected %0o", tag, got, exp);
    end
  endtask

  // One complete request on instance d, checking timing and response fields.
  task automatic run_txn(input int d, input logic we, input logic [0:2] f, input logic [0:11] a,
                         input logic [0:11] wd, input logic inj, input logic [0:11] exp_rd,
                         input logic exp_nxm, input logic exp_perr);
    int          ws;
    int          lat;
    int          low;
    int          wt;
    logic [0:11] rd;
    logic        nx;
    logic        pe;
    logic        rdy_after;
    logic        vld_after;
    ws  = (d == 0) ? 0 : 3;
    lat = 0;
    low = 0;
    wt  = 0;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_field[d]  = f;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    par_inject[d] = inj;
    while (!req_ready[d] && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    check("accept_wait", 32'(wt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    while (!rsp_valid[d] && lat < 40) begin
      if (!req_ready[d]) low++;
      @(negedge clk);
      lat++;
    end
    if (!req_ready[d]) low++;
    rd = rsp_rdata[d];
    nx = rsp_nxm[d];
    pe = rsp_par_err[d];
    @(negedge clk);
    rdy_after = req_ready[d];
    vld_after = rsp_valid[d];
    $display("TXN dut%0d %s f%0o a%04o wd%04o inj%0b -> rdata %04o nxm %0b perr %0b lat %0d",
             d, we ? "WR" : "RD", f, a, wd, inj, rd, nx, pe, lat);
    check("latency",     32'(lat), 32'(ws + 1));
    check("ready_low",   32'(low), 32'(ws + 2));
    check("rdata",       32'(rd), 32'(exp_rd));
    check("nxm",         32'(nx), 32'(exp_nxm));
    check("par_err",     32'(pe), 32'(exp_perr));
    check("ready_after", 32'(rdy_after), 32'd1);
    check("one_cycle",   32'(vld_after), 32'd0);
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check({tag, "_ready"}, 32'(req_ready[d]),   32'd1);
    check({tag, "_valid"}, 32'(rsp_valid[d]),   32'd0);
    check({tag, "_rdata"}, 32'(rsp_rdata[d]),   32'd0);
    check({tag, "_nxm"},   32'(rsp_nxm[d]),     32'd0);
    check({tag, "_perr"},  32'(rsp_par_err[d]), 32'd0);
  endtask

  initial begin
    logic [0:11] bd   [4];
    logic [0:11] got  [4];
    int          acc  [4];
    int          idx;
    int          rcount;
    logic        pend;

    for (int d = 0; d < 2; d++) begin
      reset[d]      = 1'b1;
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_field[d]  = '0;
      req_addr[d]   = '0;
      req_wdata[d]  = '0;
      par_inject[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    // Zero wait states: write then read back.
    run_txn(0, 1'b1, 3'o0, 12'o0100, 12'o1234, 1'b0, 12'o0000, 1'b0, 1'b0);
    run_txn(0, 1'b0, 3'o0, 12'o0100, 12'o0000, 1'b0, 12'o1234, 1'b0, 1'b0);

    // Three wait states, top word of field 1 distinct from top word of field 0.
    run_txn(1, 1'b1, 3'o1, 12'o7777, 12'o4321, 1'b0, 12'o0000, 1'b0, 1'b0);
    run_txn(1, 1'b1, 3'o0, 12'o7777, 12'o1357, 1'b0, 12'o0000, 1'b0, 1'b0);
    run_txn(1, 1'b0, 3'o1, 12'o7777, 12'o0000, 1'b0, 12'o4321, 1'b0, 1'b0);
    run_txn(1, 1'b0, 3'o0, 12'o7777, 12'o0000, 1'b0, 12'o1357, 1'b0, 1'b0);

    // Nonexistent field 2 aliases physical word 0 of field 0 if writes are not gated.
    run_txn(0, 1'b1, 3'o0, 12'o0000, 12'o2222, 1'b0, 12'o0000, 1'b0, 1'b0);
    run_txn(0, 1'b1, 3'o2, 12'o0000, 12'o5555, 1'b0, 12'o0000, 1'b1, 1'b0);
    run_txn(0, 1'b0, 3'o2, 12'o0000, 12'o0000, 1'b0, 12'o0000, 1'b1, 1'b0);
    run_txn(0, 1'b0, 3'o0, 12'o0000, 12'o0000, 1'b0, 12'o2222, 1'b0, 1'b0);

    // Back-to-back reads with req_valid held high.
    for (int i = 0; i < 4; i++) begin
      bd[i] = 12'((i + 1) * 'o111);
      run_txn(0, 1'b1, 3'o0, 12'(12'o0200 + i), bd[i], 1'b0, 12'o0000, 1'b0, 1'b0);
    end
    idx    = 0;
    rcount = 0;
    pend   = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_field[0] = 3'o0;
    req_addr[0]  = 12'o0200;
    for (int n = 0; n < 60 && rcount < 4; n++) begin
      if (rsp_valid[0]) begin
        got[rcount] = rsp_rdata[0];
        $display("TXN dut0 RD b2b #%0d -> rdata %04o at cycle %0d", rcount, got[rcount], cyc);
        rcount++;
      end
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < 4) req_addr[0] = 12'(12'o0200 + idx);
        else         req_valid[0] = 1'b0;
      end
      if (req_valid[0] && req_ready[0]) begin
        pend     = 1'b1;
        acc[idx] = cyc;
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    repeat (6) begin
      if (rsp_valid[0]) rcount++;
      @(negedge clk);
    end
    check("b2b_count", 32'(rcount), 32'd4);
    for (int i = 0; i < 3; i++) check("b2b_gap", 32'(acc[i + 1] - acc[i]), 32'd3);
    for (int i = 0; i < 4; i++) check("b2b_data", 32'(got[i]), 32'(bd[i]));

    // Reset during the ACCESS cycle of a write must suppress it.
    run_txn(0, 1'b1, 3'o0, 12'o0300, 12'o1111, 1'b0, 12'o0000, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_acc_ready", 32'(req_ready[0]), 32'd1);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_field[0] = 3'o0;
    req_addr[0]  = 12'o0300;
    req_wdata[0] = 12'o0707;
    @(negedge clk);
    check("in_access_ready", 32'(req_ready[0]), 32'd0);
    req_valid[0] = 1'b0;
    reset[0]     = 1'b1;
    @(negedge clk);
    check_idle_outputs(0, "midreset");
    reset[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_rsp_after_reset", 32'(rsp_valid[0]), 32'd0);
    end
    $display("TXN dut0 WR f0 a0300 wd0707 aborted by reset");
    run_txn(0, 1'b0, 3'o0, 12'o0300, 12'o0000, 1'b0, 12'o1111, 1'b0, 1'b0);

    // Parity injection (flags only when parity is built in).
    run_txn(0, 1'b1, 3'o0, 12'o0400, 12'o0001, 1'b1, 12'o0000, 1'b0, 1'b0);
    run_txn(0, 1'b0, 3'o0, 12'o0400, 12'o0000, 1'b0, 12'o0001, 1'b0, PAR_EN);
    run_txn(0, 1'b1, 3'o0, 12'o0400, 12'o0001, 1'b0, 12'o0000, 1'b0, 1'b0);
    run_txn(0, 1'b0, 3'o0, 12'o0400, 12'o0000, 1'b0, 12'o0001, 1'b0, 1'b0);
    run_txn(0, 1'b1, 3'o3, 12'o0400, 12'o0001, 1'b1, 12'o0000, 1'b1, 1'b0);
    run_txn(0, 1'b0, 3'o3, 12'o0400, 12'o0000, 1'b0, 12'o0000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
